// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N requesters.
// Each grant covers up to BURST accepted beats; writes are suppressed while full.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int width = 8,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*width-1:0] req_data,
  input  logic               full,
  output logic [N-1:0]       gnt,
  output logic               wr,
  output logic [width-1:0]   wr_data,
  output logic               busy
);

  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg;
  logic [N-1:0]     gnt_reg;
  logic [N-1:0]     gnt_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] last_reg;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W:0]   cand;
  logic             win_found;
  logic             last_beat;
  logic             release_gnt;
  logic [N-1:0]     arb_req;
  logic [width-1:0] slice [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*width +: width];
    end
  endgenerate

  // While a grant is held, last_reg is the granted index.
  assign wr          = gnt_reg[last_reg] & req[last_reg] & ~full & ~rst;
  assign wr_data     = (gnt_reg != '0) ? slice[last_reg] : '0;
  assign last_beat   = wr && (cnt_reg == CNT_W'(BURST - 1));
  assign release_gnt = last_beat || !req[last_reg];
  assign gnt         = gnt_reg;
  assign busy        = (state_reg == GRANT);

  // A holder finishing its burst still competes, as the last candidate.
  always_comb begin
    arb_req = req;
    if (last_beat) arb_req[last_reg] = 1'b1;
  end

  // Walk offsets from N down to 1 so the nearest candidate after last_reg wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_reg;
    cand      = '0;
    for (int k = N; k >= 1; k--) begin
      cand = {1'b0, last_reg} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (arb_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    gnt_next          = '0;
    gnt_next[win_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      cnt_reg   <= '0;
      last_reg  <= IDX_W'(N - 1);
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            state_reg <= GRANT;
            gnt_reg   <= gnt_next;
            last_reg  <= win_idx;
            cnt_reg   <= '0;
          end
        end
        GRANT: begin
          if (release_gnt) begin
            cnt_reg <= '0;
            if (win_found) begin
              gnt_reg  <= gnt_next;
              last_reg <= win_idx;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= '0;
            end
          end else if (wr) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single requester, round robin,
// full stall, request drop and reset mid-burst, checked cycle by cycle.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt;
  logic        wr;
  logic [7:0]  wr_data;
  logic        busy;

  logic [7:0] dat [4];
  int wcnt [4];
  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(.N(4), .width(8), .BURST(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .wr(wr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = dat[i];
  end

  // One cycle: compare outputs, then let the writing requester advance its data.
  task automatic chk(input string tag, input logic [3:0] eg, input logic ew,
                     input logic [7:0] ed, input logic eb);
    logic       wr_seen;
    logic [3:0] gnt_seen;
    #1;
    checks++;
    assert (gnt === eg) else begin
      errors++; $error("FAIL %s gnt got %b exp %b", tag, gnt, eg);
    end
    checks++;
    assert (wr === ew) else begin
      errors++; $error("FAIL %s wr got %b exp %b", tag, wr, ew);
    end
    checks++;
    assert (wr_data === ed) else begin
      errors++; $error("FAIL %s wr_data got %h exp %h", tag, wr_data, ed);
    end
    checks++;
    assert (busy === eb) else begin
      errors++; $error("FAIL %s busy got %b exp %b", tag, busy, eb);
    end
    $display("%-10s req=%b full=%b rst=%b gnt=%b wr=%b data=%h busy=%b",
             tag, req, full, rst, gnt, wr, wr_data, busy);
    wr_seen  = wr;
    gnt_seen = gnt;
    @(posedge clk);
    #1;
    if (wr_seen === 1'b1)
      for (int i = 0; i < 4; i++)
        if (gnt_seen[i]) begin
          dat[i] = dat[i] + 8'd1;
          wcnt[i]++;
        end
    @(negedge clk);
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++; $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
    $display("%-10s count=%0d", tag, got);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dat[i]  = 8'h20 + 8'(16 * i);
      wcnt[i] = 0;
    end
    @(negedge clk);

    // Reset held with all requesting
    req = 4'b1111;
    repeat (3) chk("reset", 4'b0000, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    chk("rel", 4'b0000, 1'b0, 8'h00, 1'b0);

    // All request: four back-to-back bursts of four beats
    for (int r = 0; r < 4; r++)
      for (int b = 0; b < 4; b++)
        chk("all", 4'(1 << r), 1'b1, 8'(8'h20 + 16 * r + b), 1'b1);
    chk("all_wrap", 4'b0001, 1'b1, 8'h24, 1'b1);
    req = 4'b0000;
    chk("all_end", 4'b0001, 1'b0, 8'h25, 1'b1);
    chk("idle", 4'b0000, 1'b0, 8'h00, 1'b0);

    // Single requester across burst boundaries
    req    = 4'b0100;
    dat[2] = 8'h10;
    chk("single_lat", 4'b0000, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < 10; k++)
      chk("single", 4'b0100, 1'b1, 8'(8'h10 + k), 1'b1);
    req = 4'b0000;
    chk("single_end", 4'b0100, 1'b0, 8'h1a, 1'b1);
    chk("idle", 4'b0000, 1'b0, 8'h00, 1'b0);

    // Full stall during requester 0 burst
    for (int i = 0; i < 4; i++) wcnt[i] = 0;
    req    = 4'b0011;
    dat[0] = 8'h40;
    dat[1] = 8'h50;
    chk("idle", 4'b0000, 1'b0, 8'h00, 1'b0);
    chk("stall_b1", 4'b0001, 1'b1, 8'h40, 1'b1);
    chk("stall_b2", 4'b0001, 1'b1, 8'h41, 1'b1);
    full = 1'b1;
    repeat (3) chk("stall_full", 4'b0001, 1'b0, 8'h42, 1'b1);
    full = 1'b0;
    chk("stall_b3", 4'b0001, 1'b1, 8'h42, 1'b1);
    chk("stall_b4", 4'b0001, 1'b1, 8'h43, 1'b1);

    // Request drop: requester 1 leaves after two beats, requester 3 waits
    req    = 4'b1010;
    dat[3] = 8'h60;
    chk("drop_b1", 4'b0010, 1'b1, 8'h50, 1'b1);
    chk_int("stall_wr0", wcnt[0], 4);
    chk("drop_b2", 4'b0010, 1'b1, 8'h51, 1'b1);
    req = 4'b1000;
    chk("drop", 4'b0010, 1'b0, 8'h52, 1'b1);
    chk("drop_next", 4'b1000, 1'b1, 8'h60, 1'b1);
    chk_int("drop_wr1", wcnt[1], 2);
    chk("drop_b2n", 4'b1000, 1'b1, 8'h61, 1'b1);
    req = 4'b0000;
    chk("drop_end", 4'b1000, 1'b0, 8'h62, 1'b1);
    chk("idle", 4'b0000, 1'b0, 8'h00, 1'b0);

    // Reset during beat 3 of requester 2
    req    = 4'b0100;
    dat[2] = 8'h70;
    chk("idle", 4'b0000, 1'b0, 8'h00, 1'b0);
    req = 4'b1111;
    chk("mid_b1", 4'b0100, 1'b1, 8'h70, 1'b1);
    chk("mid_b2", 4'b0100, 1'b1, 8'h71, 1'b1);
    rst = 1'b1;
    chk("mid_rst", 4'b0100, 1'b0, 8'h72, 1'b1);
    rst = 1'b0;
    chk("mid_after", 4'b0000, 1'b0, 8'h00, 1'b0);
    for (int b = 0; b < 4; b++)
      chk("mid_r0", 4'b0001, 1'b1, 8'(8'h44 + b), 1'b1);
    chk("mid_r1", 4'b0010, 1'b1, 8'h52, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the write side of one asynchronous FIFO among N requesters in the write clock domain. Grants one requester at a time for a burst of up to BURST beats. Drives the FIFO's `wr`/`wr_data` directly and never writes while the FIFO reports `full`. Sits between the requester blocks and the FIFO write port, clocked by the FIFO write clock.

## Interface
- `N`, default 4: number of requesters (≥2).
- `width`, default 8: data width; must equal the FIFO data width.
- `BURST`, default 4: maximum beats per grant (≥1).

- `clk`  in  1: FIFO write-domain clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `req`  in  N: per-requester request; requester i holds `req[i]` while it has data.
- `req_data`  in  N*width: requester i data at bits [i*width +: width].
- `full`  in  1: FIFO full flag, from the FIFO write side.
- `gnt`  out  N: registered one-hot grant, or all-zero.
- `wr`  out  1: FIFO write enable (combinational).
- `wr_data`  out  width: FIFO write data, equal to `req_data` slice of the granted requester.
- `busy`  out  1: registered; high when a grant is held.

## Operation
- State: IDLE / GRANT.
- Registers: `gnt`, beat counter `cnt` (width $clog2(BURST+1)), round-robin pointer `last` (index of last granted requester).
- Arbitration: pick the first i with `req[i]`=1, searching `last+1, last+2, … mod N`, wrapping, and including `last` itself as the final candidate.
- IDLE: if any `req` is set, arbitrate and go to GRANT next edge with `gnt`=onehot(i), `last`=i, `cnt`=0. Otherwise stay in IDLE.
- GRANT, granted index g:
  - Beat accepted in a cycle iff `gnt[g]` & `req[g]` & !`full` & !`rst`. That term is `wr`.
  - Requester g advances its data after each edge where `wr`=1.
  - `wr_data` = `req_data[g]` whenever `gnt`≠0; otherwise 0.
  - On each accepted beat, `cnt` increments.
  - Release condition: (accepted beat and `cnt`=BURST-1) or `req[g]`=0.
  - On release, re-arbitrate in the same cycle, with `last`=g, using the current `req` vector. For release on the final burst beat, `req[g]` counts as still set.
  - If re-arbitration finds a winner, load the new grant with `cnt`=0. Otherwise go to IDLE and clear `gnt`.
- `full`: stalls the burst. `gnt` is held and `cnt` is frozen; there is no timeout.
- Single active requester: re-granted to itself at the burst boundary with no gap.
- `busy` = (state == GRANT).
- Reset (any cycle, including mid-burst):
  - `wr` is forced 0 in the reset cycle.
  - After the edge: `gnt`=0, `busy`=0, `cnt`=0, `last`=N-1, so the first search starts at requester 0.
  - No partial-burst state survives reset.

## Timing
- Reset values: `gnt`=0, `busy`=0, `wr`=0, `wr_data`=0.
- Request-to-grant latency from IDLE: `gnt` rises on the edge after `req` is first sampled; the first `wr` can occur in that cycle.
- Throughput: one beat per clock while `req[g]`=1 and `full`=0.
- Burst-boundary handover: zero bubble. The next grant is active in the cycle after the last beat.
- Request-drop handover: the cycle where `req[g]`=0 transfers nothing; the new grant is active the next cycle (1-cycle gap).
- `full` is sampled combinationally in the same cycle as `wr`. This guarantees no write in any cycle where `full`=1.

## Test plan
- **Reset:** `rst`=1 for 3 cycles with `req`=4'b1111.
  - Required: `gnt`=0, `wr`=0, `busy`=0 throughout.
  - The first edge after reset release gives `gnt`=4'b0001.
- **Single requester:** `req`=4'b0100 held, `full`=0, data 8'h10, 8'h11, ….
  - Required: `gnt`=4'b0100 one cycle after `req`.
  - `wr`=1 every cycle thereafter, including across burst boundaries.
  - FIFO receives 8'h10, 8'h11, … in order.
- **All request, BURST=4:** `req`=4'b1111 held.
  - Required grant order: 0001, 0010, 0100, 1000, 0001, with 4 beats each.
  - 16 writes in 16 consecutive cycles, no bubble.
- **Full stall:** `full`=1 for 3 cycles after beat 2 of requester 0.
  - Required: `wr`=0 for those 3 cycles and `gnt` stays 4'b0001.
  - Beats 3–4 follow once `full`=0, then the grant moves to the next requester.
  - Exactly 4 writes from requester 0.
- **Request drop:** `req[1]` drops after 2 beats while `req[3]`=1.
  - Required: no write in the drop cycle; `gnt`=4'b1000 on the next edge.
  - Requester 1 has exactly 2 writes.
- **Reset mid-burst:** assert `rst` during beat 3 of requester 2, with all requesters requesting.
  - Required: `wr`=0 in the reset cycle and `gnt`=0 after the edge.
  - After release, first grant is 4'b0001 and `cnt` restarts at 0.
